bird_ctrl_n: RTL and testbench

Parametrised bird controller for the Flappy Bird game: integrates flap and gravity physics with a signed velocity, checks collisions against NUM_PIPES pipe pairs, and scores each pipe once per pass. It runs a start/play/pause/dead state machine and keeps current and high score. Sits between the keyboard keycode decoder and the pipe generator / VGA sprite and score renderers; `game_end` feeds back to the pipe generator.

---
 rtl/flappy_pkg.sv | 25 ++
 rtl/bird_ctrl_n_if.sv | 25 ++
 rtl/bird_ctrl_n_pipe_hit_check.sv | 32 +++
 rtl/bird_ctrl_n.sv | 143 ++++++++++++++
 tb/tb_bird_ctrl_n.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encoding, key codes and screen constants for the bird controller
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [7:0] KEY_FLAP    = 8'h2C;
    localparam logic [7:0] KEY_RESTART = 8'h15;
    localparam logic [7:0] KEY_PAUSE   = 8'h13;

    localparam int SCREEN_Y_MAX = 479;
    localparam int BIRD_X0      = 120;
    localparam int BIRD_Y0      = 240;

    // Screen coordinates are unsigned 10-bit; widen to 12-bit signed so that
    // subtracting half-widths near zero stays negative instead of wrapping.
    function automatic logic signed [11:0] sx12(input logic [9:0] v);
        return signed'({2'b00, v});
    endfunction

endpackage

// File: rtl/bird_ctrl_n_if.sv
// bird_ctrl_n_if: key/pipe inputs and bird/score outputs of the bird controller
interface bird_ctrl_n_if #(
    parameter int NUM_PIPES = 4
);
    logic [7:0] keycode;
    logic [9:0] pipe_x [NUM_PIPES];
    logic [9:0] pipe_y [NUM_PIPES];
    logic [9:0] bird_x;
    logic [9:0] bird_y;
    logic [9:0] bird_s;
    logic       game_end;
    logic [1:0] state_o;
    logic [7:0] current_score;
    logic [7:0] high_score;

    modport master (
        output keycode, pipe_x, pipe_y,
        input  bird_x, bird_y, bird_s, game_end, state_o, current_score, high_score
    );

    modport slave (
        input  keycode, pipe_x, pipe_y,
        output bird_x, bird_y, bird_s, game_end, state_o, current_score, high_score
    );
endinterface

// File: rtl/bird_ctrl_n_pipe_hit_check.sv
// pipe_hit_check: collision and passed tests of the bird box against one pipe pair
module pipe_hit_check
    import flappy_pkg::*;
#(
    parameter int BIRD_SIZE = 7,
    parameter int PIPE_HW   = 25,
    parameter int GAP_HALF  = 75
) (
    input  logic [9:0] i_bird_x,
    input  logic [9:0] i_bird_y,
    input  logic [9:0] i_pipe_x,
    input  logic [9:0] i_pipe_y,
    output logic       o_hit,
    output logic       o_passed
);
    localparam logic signed [11:0] L_S  = 12'(BIRD_SIZE);
    localparam logic signed [11:0] L_HW = 12'(PIPE_HW);
    localparam logic signed [11:0] L_G  = 12'(GAP_HALF);

    logic signed [11:0] w_bx, w_by, w_px, w_py;
    logic               w_x_overlap, w_outside_gap;

    assign w_bx = sx12(i_bird_x);
    assign w_by = sx12(i_bird_y);
    assign w_px = sx12(i_pipe_x);
    assign w_py = sx12(i_pipe_y);

    assign w_x_overlap   = (w_bx + L_S >= w_px - L_HW) && (w_bx - L_S <= w_px + L_HW);
    assign w_outside_gap = (w_by - L_S < w_py - L_G) || (w_by + L_S > w_py + L_G);
    assign o_hit         = w_x_overlap && w_outside_gap;
    assign o_passed      = w_px + L_HW < w_bx - L_S;
endmodule

// File: rtl/bird_ctrl_n.sv
// bird_ctrl_n: flap/gravity physics, pipe collision, scoring and game state machine
module bird_ctrl_n
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int BIRD_SIZE = 7,
    parameter int PIPE_HW   = 25,
    parameter int GAP_HALF  = 75,
    parameter int FLAP_VEL  = 3,
    parameter int GRAV_DIV  = 3,
    parameter int VMAX      = 6
) (
    input  logic         Reset,
    input  logic         frame_clk,
    bird_ctrl_n_if.slave bus
);
    localparam int                 GW     = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic signed [11:0] L_S    = 12'(BIRD_SIZE);
    localparam logic signed [11:0] L_YMAX = 12'(SCREEN_Y_MAX);
    localparam logic signed [9:0]  L_FLAP = 10'(FLAP_VEL);
    localparam logic signed [9:0]  L_VMAX = 10'(VMAX);

    state_t                r_state;
    logic [7:0]            r_prev_key;
    logic [9:0]            r_bird_y;
    logic signed [9:0]     r_vel;
    logic [GW-1:0]         r_grav;
    logic [7:0]            r_cur;
    logic [7:0]            r_high;
    logic [NUM_PIPES-1:0]  r_scored;
    logic                  r_game_end;

    logic [NUM_PIPES-1:0]  w_hit_pipe, w_passed, w_new;
    logic                  w_flap, w_restart, w_pause, w_bound, w_hit, w_grav_wrap;
    logic signed [11:0]    w_by, w_y_sum;
    logic signed [9:0]     w_vel_next;
    logic [GW-1:0]         w_grav_next;
    logic [9:0]            w_y_next;
    logic [9:0]            w_sum;
    logic [7:0]            w_cur_next;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        pipe_hit_check #(
            .BIRD_SIZE (BIRD_SIZE),
            .PIPE_HW   (PIPE_HW),
            .GAP_HALF  (GAP_HALF)
        ) u_chk (
            .i_bird_x (10'(BIRD_X0)),
            .i_bird_y (r_bird_y),
            .i_pipe_x (bus.pipe_x[i]),
            .i_pipe_y (bus.pipe_y[i]),
            .o_hit    (w_hit_pipe[i]),
            .o_passed (w_passed[i])
        );
    end

    assign w_flap    = bus.keycode == KEY_FLAP    && r_prev_key != KEY_FLAP;
    assign w_restart = bus.keycode == KEY_RESTART && r_prev_key != KEY_RESTART;
    assign w_pause   = bus.keycode == KEY_PAUSE   && r_prev_key != KEY_PAUSE;

    assign w_by    = sx12(r_bird_y);
    assign w_bound = (w_by - L_S <= 12'sd0) || (w_by + L_S >= L_YMAX);
    assign w_hit   = w_bound || |w_hit_pipe;

    // A flap resets the gravity phase; otherwise velocity grows once every GRAV_DIV frames up to VMAX
    assign w_grav_wrap = r_grav == GW'(GRAV_DIV - 1);
    assign w_grav_next = (w_flap || w_grav_wrap) ? '0 : r_grav + 1'b1;
    assign w_vel_next  = w_flap ? -L_FLAP :
                         (w_grav_wrap && r_vel < L_VMAX) ? r_vel + 10'sd1 : r_vel;

    // The position moves by the freshly computed velocity and is clamped to the screen
    assign w_y_sum  = w_by + {{2{w_vel_next[9]}}, w_vel_next};
    assign w_y_next = (w_y_sum < 12'sd0) ? '0 :
                      (w_y_sum > L_YMAX) ? 10'(SCREEN_Y_MAX) : w_y_sum[9:0];

    // Each pipe that has just moved behind the bird adds one point; the score saturates
    assign w_new = w_passed & ~r_scored;
    always_comb begin
        w_sum = {2'b00, r_cur};
        for (int k = 0; k < NUM_PIPES; k++) w_sum = w_sum + 10'(w_new[k]);
    end
    assign w_cur_next = (w_sum > 10'd255) ? 8'd255 : w_sum[7:0];

    // Game state machine with all per-frame physics, scoring and output registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_prev_key <= '0;
            r_bird_y   <= 10'(BIRD_Y0);
            r_vel      <= '0;
            r_grav     <= '0;
            r_cur      <= '0;
            r_high     <= '0;
            r_scored   <= '0;
            r_game_end <= 1'b0;
        end else begin
            r_prev_key <= bus.keycode;
            if (w_restart && r_state != IDLE) begin
                r_state    <= IDLE;
                r_bird_y   <= 10'(BIRD_Y0);
                r_vel      <= '0;
                r_grav     <= '0;
                r_game_end <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_flap) begin
                        r_state  <= PLAY;
                        r_vel    <= w_vel_next;
                        r_grav   <= '0;
                        r_bird_y <= w_y_next;
                        r_cur    <= '0;
                        r_scored <= '0;
                    end
                    PLAY: if (w_pause) begin
                        r_state <= PAUSE;
                    end else if (w_hit) begin
                        r_state    <= DEAD;
                        r_vel      <= '0;
                        r_game_end <= 1'b1;
                        r_high     <= (r_cur > r_high) ? r_cur : r_high;
                    end else begin
                        r_vel    <= w_vel_next;
                        r_grav   <= w_grav_next;
                        r_bird_y <= w_y_next;
                        r_cur    <= w_cur_next;
                        r_scored <= w_passed;
                    end
                    PAUSE: if (w_pause) r_state <= PLAY;
                    DEAD:  r_state <= DEAD;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.bird_x        = 10'(BIRD_X0);
    assign bus.bird_y        = r_bird_y;
    assign bus.bird_s        = 10'(BIRD_SIZE);
    assign bus.game_end      = r_game_end;
    assign bus.state_o       = r_state;
    assign bus.current_score = r_cur;
    assign bus.high_score    = r_high;
endmodule

// File: tb/tb_bird_ctrl_n.sv
// tb_bird_ctrl_n: directed frames with hand-computed expectations, checked by a queue-driven monitor
module tb_bird_ctrl_n;
    localparam logic [7:0] K_F = 8'h2C;
    localparam logic [7:0] K_R = 8'h15;
    localparam logic [7:0] K_P = 8'h13;
    localparam int F_ST = 0, F_Y = 1, F_GE = 2, F_CUR = 3, F_HI = 4, F_X = 5, F_S = 6;

    typedef struct {
        int cyc;
        int fld;
        int val;
    } exp_t;

    logic  Reset;
    logic  frame_clk;
    int    cyc = 0;
    int    e = -1;
    int    checks = 0;
    int    failures = 0;
    exp_t  q[$];
    event  samp;
    string names[7] = '{"state", "bird_y", "game_end", "current_score", "high_score", "bird_x", "bird_s"};

    bird_ctrl_n_if #(.NUM_PIPES(4)) bus ();

    bird_ctrl_n #(.NUM_PIPES(4)) dut (
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic int get(input int f);
        case (f)
            F_ST:    return int'(bus.state_o);
            F_Y:     return int'(bus.bird_y);
            F_GE:    return int'(bus.game_end);
            F_CUR:   return int'(bus.current_score);
            F_HI:    return int'(bus.high_score);
            F_X:     return int'(bus.bird_x);
            default: return int'(bus.bird_s);
        endcase
    endfunction

    task automatic flush();
        exp_t x;
        int   act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            act = get(x.fld);
            checks++;
            if (x.cyc != cyc || act != x.val) begin
                failures++;
                $display("FAIL %s cyc=%0d actual=%0d expected=%0d", names[x.fld], x.cyc, act, x.val);
            end
        end
    endtask

    always @(posedge frame_clk) begin
        cyc++;
        #1 flush();
    end

    always @(samp) flush();

    task automatic ex(input int f, input int v);
        q.push_back('{cyc: cyc + 1, fld: f, val: v});
    endtask

    task automatic ex_now(input int f, input int v);
        q.push_back('{cyc: cyc, fld: f, val: v});
    endtask

    task automatic go(input logic [7:0] k);
        @(negedge frame_clk);
        bus.keycode = k;
        e++;
    endtask

    task automatic pipes_home();
        for (int i = 0; i < 4; i++) begin
            bus.pipe_x[i] = 10'd639;
            bus.pipe_y[i] = 10'd240;
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.keycode = 8'h00;
        pipes_home();
        repeat (3) @(negedge frame_clk);
        Reset = 1'b0;
        ex(F_ST, 0); ex(F_Y, 240); ex(F_X, 120); ex(F_S, 7); ex(F_GE, 0); ex(F_CUR, 0); ex(F_HI, 0);

        go(K_F); ex(F_ST, 1); ex(F_Y, 237);
        while (e < 3) go(0);
        ex(F_Y, 229);
        go(0); bus.pipe_x[0] = 10'd120; ex(F_CUR, 0); ex(F_Y, 227); ex(F_ST, 1);
        go(0); ex(F_ST, 1);
        go(0); bus.pipe_x[0] = 10'd80; ex(F_CUR, 1);
        go(0); ex(F_CUR, 1);
        go(0); bus.pipe_x[0] = 10'd639;
        go(0); bus.pipe_x[0] = 10'd80; ex(F_CUR, 2);
        go(0); bus.pipe_x[0] = 10'd639;
        go(0);
        go(0); bus.pipe_x[1] = 10'd80; bus.pipe_x[2] = 10'd80; ex(F_CUR, 4); ex(F_Y, 223);
        go(0); bus.pipe_x[1] = 10'd639; bus.pipe_x[2] = 10'd639;
        while (e < 30) go(0);
        ex(F_Y, 291);
        while (e < 33) go(0);
        ex(F_Y, 309);

        go(K_F); ex(F_Y, 306);
        while (e < 43) go(K_F);
        ex(F_Y, 291);

        while (e < 61) go(0);
        ex(F_Y, 342);
        go(K_P); ex(F_ST, 2); ex(F_Y, 342);
        while (e < 81) go(K_P);
        ex(F_ST, 2); ex(F_Y, 342);
        go(0);
        go(K_P); ex(F_ST, 1); ex(F_Y, 342);
        go(0); ex(F_Y, 348);

        while (e < 105) go(0);
        ex(F_Y, 474); ex(F_ST, 1);
        go(0); ex(F_ST, 3); ex(F_GE, 1); ex(F_HI, 4); ex(F_Y, 474);
        go(K_F); ex(F_ST, 3); ex(F_Y, 474);
        go(K_R); ex(F_ST, 0); ex(F_Y, 240); ex(F_CUR, 4); ex(F_HI, 4); ex(F_GE, 0);
        go(K_F); ex(F_ST, 1); ex(F_CUR, 0); ex(F_Y, 237); ex(F_HI, 4);

        go(0); bus.pipe_x[1] = 10'd80; ex(F_CUR, 1); ex(F_Y, 234);
        go(0); bus.pipe_x[0] = 10'd120; bus.pipe_y[0] = 10'd100; bus.pipe_x[2] = 10'd80;
        ex(F_ST, 3); ex(F_GE, 1); ex(F_CUR, 1); ex(F_HI, 4);
        go(K_R); pipes_home(); ex(F_ST, 0); ex(F_GE, 0);
        go(K_F); ex(F_ST, 1); ex(F_CUR, 0);
        go(K_P); ex(F_ST, 2); ex(F_Y, 237);

        @(negedge frame_clk);
        #2 Reset = 1'b1;
        #1;
        ex_now(F_ST, 0); ex_now(F_Y, 240); ex_now(F_CUR, 0); ex_now(F_HI, 0); ex_now(F_GE, 0); ex_now(F_X, 120);
        ->samp;
        @(negedge frame_clk);
        bus.keycode = 8'h00;
        ex(F_ST, 0); ex(F_Y, 240); ex(F_HI, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        repeat (3) @(negedge frame_clk);

        while (q.size() > 0) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=unchecked expected=%0d", names[q[0].fld], q[0].cyc, q[0].val);
            void'(q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
